// File: rtl/ysyx_210184_inst_fetch_axi_pkg.sv
// Shared constants, AXI encodings and fetch FSM state type for the
// instruction-fetch AXI bridge.
package ysyx_210184_inst_fetch_axi_pkg;

  // Canonical RISC-V nop (addi x0, x0, 0), handed to IF as a bubble.
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

  // AXI4 read-channel encodings used by the fetcher.
  localparam logic [2:0]  SIZE_8B    = 3'b011;
  localparam logic [1:0]  BURST_INCR = 2'b01;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [7:0]  LEN_SINGLE = 8'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } fetch_state_e;

  // Byte address of the doubleword that a line tag names.
  function automatic logic [63:0] line_addr(input logic [60:0] tag);
    return {tag, 3'b000};
  endfunction

endpackage

// File: rtl/ysyx_210184_inst_fetch_axi_if.sv
// AXI4 read-address / read-data channels between the fetch bridge
// (master) and the memory interconnect (slave).
interface ysyx_210184_inst_fetch_axi_if;
  import ysyx_210184_inst_fetch_axi_pkg::*;

  logic        ar_valid_o;
  logic        ar_ready_i;
  logic [63:0] ar_addr_o;
  logic [3:0]  ar_id_o;
  logic [2:0]  ar_size_o;
  logic [7:0]  ar_len_o;
  logic [1:0]  ar_burst_o;
  logic        r_valid_i;
  logic        r_ready_o;
  logic [63:0] r_data_i;
  logic [1:0]  r_resp_i;
  logic        r_last_i;

  modport master (
    output ar_valid_o, ar_addr_o, ar_id_o, ar_size_o, ar_len_o, ar_burst_o,
    output r_ready_o,
    input  ar_ready_i, r_valid_i, r_data_i, r_resp_i, r_last_i
  );

  modport slave (
    input  ar_valid_o, ar_addr_o, ar_id_o, ar_size_o, ar_len_o, ar_burst_o,
    input  r_ready_o,
    output ar_ready_i, r_valid_i, r_data_i, r_resp_i, r_last_i
  );

endinterface

// File: rtl/ysyx_210184_fetch_line_buf.sv
// Single-entry doubleword line buffer: holds one fetched line, compares
// its tag against the current PC and selects the addressed 32-bit word.
module ysyx_210184_fetch_line_buf #(
  parameter logic [31:0] NOP_INST = ysyx_210184_inst_fetch_axi_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] i_pc,
  input  logic        i_fence,
  input  logic        i_fill_en,
  input  logic [60:0] i_fill_tag,
  input  logic [63:0] i_fill_data,
  input  logic        i_fill_fault,
  output logic        o_hit,
  output logic [31:0] o_inst,
  output logic        o_fault
);
  import ysyx_210184_inst_fetch_axi_pkg::*;

  logic        r_buf_valid;
  logic [60:0] r_buf_tag;
  logic [63:0] r_buf_data;
  logic        r_buf_fault;
  logic        w_unused;

  // Instructions are 4-byte aligned, so the two low PC bits carry nothing.
  assign w_unused = ^i_pc[1:0];

  // Valid bit: a fence wins over a simultaneous fill so the line is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf_valid <= 1'b0;
    end else if (i_fence) begin
      r_buf_valid <= 1'b0;
    end else if (i_fill_en) begin
      r_buf_valid <= 1'b1;
    end
  end

  // Line payload: written on every accepted response, stale or not.
  always_ff @(posedge clk) begin
    if (i_fill_en) begin
      r_buf_tag   <= i_fill_tag;
      r_buf_data  <= i_fill_data;
      r_buf_fault <= i_fill_fault;
    end
  end

  // Zero-latency hit compare and word select.
  always_comb begin
    o_hit   = r_buf_valid && (r_buf_tag == i_pc[63:3]);
    o_inst  = NOP_INST;
    o_fault = 1'b0;
    if (o_hit) begin
      o_inst  = i_pc[2] ? r_buf_data[63:32] : r_buf_data[31:0];
      o_fault = r_buf_fault;
    end
  end

endmodule

// File: rtl/ysyx_210184_inst_fetch_axi.sv
// Instruction-fetch bridge: on a line-buffer miss, issues one single-beat
// 8-byte AXI read for the PC's doubleword and fills the line buffer.
module ysyx_210184_inst_fetch_axi #(
  parameter logic [3:0]  AXI_ID   = 4'd0,
  parameter logic [31:0] NOP_INST = ysyx_210184_inst_fetch_axi_pkg::NOP_INST
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [63:0]                   pc_i,
  input  logic                          fence_i_i,
  output logic [31:0]                   inst_o,
  output logic                          ready_o,
  output logic                          fault_o,
  ysyx_210184_inst_fetch_axi_if.master  axi
);
  import ysyx_210184_inst_fetch_axi_pkg::*;

  fetch_state_e r_state, w_state_nxt;
  logic         r_ar_valid, w_ar_valid_nxt;
  logic [63:0]  r_ar_addr, w_ar_addr_nxt;
  logic         r_r_ready, w_r_ready_nxt;
  logic [60:0]  r_req_tag, w_req_tag_nxt;
  logic         w_hit;
  logic         w_fill_en;
  logic         w_fill_fault;
  logic         w_unused;

  // Single-beat bursts make the last flag redundant.
  assign w_unused     = axi.r_last_i;
  assign w_fill_fault = (axi.r_resp_i != RESP_OKAY);

  assign axi.ar_valid_o = r_ar_valid;
  assign axi.ar_addr_o  = r_ar_addr;
  assign axi.ar_id_o    = AXI_ID;
  assign axi.ar_size_o  = SIZE_8B;
  assign axi.ar_len_o   = LEN_SINGLE;
  assign axi.ar_burst_o = BURST_INCR;
  assign axi.r_ready_o  = r_r_ready;

  assign ready_o = w_hit;

  ysyx_210184_fetch_line_buf #(
    .NOP_INST (NOP_INST)
  ) u_line_buf (
    .clk          (clk),
    .rst          (rst),
    .i_pc         (pc_i),
    .i_fence      (fence_i_i),
    .i_fill_en    (w_fill_en),
    .i_fill_tag   (r_req_tag),
    .i_fill_data  (axi.r_data_i),
    .i_fill_fault (w_fill_fault),
    .o_hit        (w_hit),
    .o_inst       (inst_o),
    .o_fault      (fault_o)
  );

  // Next-state and next AXI-control values; every path holds by default.
  always_comb begin
    w_state_nxt    = r_state;
    w_ar_valid_nxt = r_ar_valid;
    w_ar_addr_nxt  = r_ar_addr;
    w_r_ready_nxt  = r_r_ready;
    w_req_tag_nxt  = r_req_tag;
    w_fill_en      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_hit) begin
          w_req_tag_nxt  = pc_i[63:3];
          w_ar_addr_nxt  = line_addr(pc_i[63:3]);
          w_ar_valid_nxt = 1'b1;
          w_state_nxt    = ADDR;
        end
      end
      ADDR: begin
        // Address is frozen here regardless of PC changes.
        if (axi.ar_ready_i) begin
          w_ar_valid_nxt = 1'b0;
          w_r_ready_nxt  = 1'b1;
          w_state_nxt    = DATA;
        end
      end
      DATA: begin
        // AXI cannot cancel, so the response is always taken and stored.
        if (axi.r_valid_i) begin
          w_fill_en     = 1'b1;
          w_r_ready_nxt = 1'b0;
          w_state_nxt   = IDLE;
        end
      end
      default: begin
        w_state_nxt    = IDLE;
        w_ar_valid_nxt = 1'b0;
        w_r_ready_nxt  = 1'b0;
      end
    endcase
  end

  // FSM state and registered AXI control outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_ar_valid <= 1'b0;
      r_ar_addr  <= 64'd0;
      r_r_ready  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ar_valid <= w_ar_valid_nxt;
      r_ar_addr  <= w_ar_addr_nxt;
      r_r_ready  <= w_r_ready_nxt;
    end
  end

  // Tag of the outstanding request, captured when the miss is seen.
  always_ff @(posedge clk) begin
    r_req_tag <= w_req_tag_nxt;
  end

endmodule

// File: doc/ysyx_210184_inst_fetch_axi.md
# ysyx_210184_inst_fetch_axi

Instruction-fetch bus bridge directly upstream of the IF stage. It takes the IF program counter, fetches the containing 64-bit aligned doubleword over an AXI4 read channel, and holds it in a single-entry line buffer. It returns the 32-bit instruction to IF together with a ready flag. IF treats a low ready as "insert bubble", so this block never needs to stall IF explicitly.

## Interface
Parameters:
- `AXI_ID`, 4'd0, value driven on `ar_id_o`; responses are assumed to carry the same ID.
- `NOP_INST`, 32'h0000_0013, instruction returned whenever `ready_o`=0.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pc_i`  in  64  fetch address from IF; bits [1:0] ignored.
- `fence_i_i`  in  1  invalidate the line buffer.
- `inst_o`  out  32  instruction for `pc_i`; equals `NOP_INST` when not ready.
- `ready_o`  out  1  `inst_o` is valid for the current `pc_i`.
- `fault_o`  out  1  qualified by `ready_o`; the line returned an AXI error.
- `ar_valid_o`  out  1  AXI read-address valid.
- `ar_ready_i`  in  1  AXI read-address ready.
- `ar_addr_o`  out  64  AXI read address.
- `ar_id_o`  out  4  AXI read ID.
- `ar_size_o`  out  3  AXI transfer size.
- `ar_len_o`  out  8  AXI burst length.
- `ar_burst_o`  out  2  AXI burst type.
- `r_valid_i`  in  1  AXI read-data valid.
- `r_ready_o`  out  1  AXI read-data ready.
- `r_data_i`  in  64  AXI read data.
- `r_resp_i`  in  2  AXI read response.
- `r_last_i`  in  1  AXI read last.

## Operation
- Line buffer holds `buf_valid`, `buf_tag` [63:3], `buf_data` [63:0] and `buf_fault`.
- Hit condition: `buf_valid` and `buf_tag == pc_i[63:3]`. This is combinational, and `ready_o` equals the hit condition.
- `inst_o` on a hit: `buf_data[63:32]` if `pc_i[2]` is set, else `buf_data[31:0]`. `fault_o` equals `buf_fault` on a hit, otherwise 0.
- AR channel constants: `ar_size_o`=3'b011, `ar_len_o`=0, `ar_burst_o`=2'b01 (INCR), `ar_id_o`=`AXI_ID`.
- FSM states are IDLE, ADDR and DATA.
  - IDLE: on a miss, latch `req_tag`=`pc_i[63:3]` and go to ADDR.
  - ADDR: `ar_valid_o`=1 and `ar_addr_o`={`req_tag`,3'b000}, both registered and held stable until `ar_ready_i`. On handshake, go to DATA.
  - DATA: `r_ready_o`=1. On `r_valid_i`, write `buf_tag`=`req_tag`, `buf_data`=`r_data_i`, `buf_fault`=(`r_resp_i`!=2'b00) and `buf_valid`=1, then go to IDLE.
- A response is always accepted, even if `pc_i` changed meanwhile (flush or jump), because AXI cannot cancel. The stale line is still written. The next IDLE cycle then re-evaluates hit/miss against the current `pc_i`.
- `pc_i` changes during ADDR do not alter `ar_addr_o` (AXI stability).
- `fence_i_i` clears `buf_valid`. If it coincides with the DATA handshake, the fill completes and `buf_valid` ends at 0.
- `r_last_i` is ignored. Single-beat responses are guaranteed by `ar_len_o`=0.

## Timing
- Reset values: state=IDLE, `buf_valid`=0, `ar_valid_o`=0, `r_ready_o`=0, `ar_addr_o`=0, and therefore `ready_o`=0, `inst_o`=`NOP_INST`, `fault_o`=0.
- Hit: zero-latency, same cycle as `pc_i`.
- Miss with zero-wait slave:
  - cycle 0: miss detected.
  - cycle 1: AR handshake.
  - cycle 2: R handshake.
  - cycle 3: `ready_o`=1.
  - Minimum miss penalty is 3 cycles.
- Sequential code: the second instruction of each doubleword hits immediately.
- At most one outstanding transaction at any time.
- Reset asserted mid-transaction clears all state immediately. The interconnect shares the reset, so no orphaned response is expected.

## Structure
- Shared package constants:
  - `NOP_INST`.
  - AXI encodings: SIZE_8B, BURST_INCR, RESP_OKAY.
  - fetch FSM state enum {IDLE, ADDR, DATA}.
- One sub-module, `ysyx_210184_fetch_line_buf`, contains:
  - the tag/data/fault/valid registers;
  - the hit compare;
  - the word select.
- FSM and AXI driving stay in the top.

## Test plan
- Cold start: after reset, pc_i=0x8000_0000, slave ar_ready=1, r_data=0x0000_0093_0000_0013 one cycle later -> AR addr 0x8000_0000 size 3, `ready_o` rises at cycle 3 with `inst_o`=0x0000_0013; pc_i=0x8000_0004 next cycle -> same-cycle hit, `inst_o`=0x0000_0093, no new AR.
- Backpressure: ar_ready low 4 cycles while pc_i toggles 0x8000_0000/0x8000_0100 -> `ar_addr_o` stays 0x8000_0000 and valid throughout; after fill, pc_i=0x8000_0100 triggers new AR.
- Jump during DATA: miss on 0x8000_0000, pc_i changes to 0x8000_0200 before R -> response accepted, buffer tag 0x8000_0000, `ready_o`=0, next AR addr 0x8000_0200.
- Error response: r_resp=2'b10 for 0x8000_0008 -> `ready_o`=1, `fault_o`=1, `inst_o`=r_data word; fence_i then forces refetch with `fault_o`=0 on OKAY.
- fence_i coinciding with R handshake -> `buf_valid`=0 next cycle, `ready_o`=0, new AR issued for same pc.
- Reset asserted in ADDR -> `ar_valid_o` drops asynchronously, `ready_o`=0, `inst_o`=0x0000_0013.
